// File: rtl/cellrv32_package.sv
// Shared types for the vector register rename stage.
// TicketBits : default producer-ticket width.
// PhysIdxW   : physical register index width for the default 64-entry file.
// ren_instr_t: one renamed instruction as seen at the rename output.
package cellrv32_package;

  localparam int unsigned TicketBits = 4;
  localparam int unsigned PhysIdxW   = 6;

  typedef struct packed {
    logic [PhysIdxW-1:0]   pdst;
    logic [PhysIdxW-1:0]   psrc1;
    logic [PhysIdxW-1:0]   psrc2;
    logic [PhysIdxW-1:0]   old_pdst;
    logic [TicketBits-1:0] ticket;
    logic [TicketBits-1:0] src1_ticket;
    logic [TicketBits-1:0] src2_ticket;
  } ren_instr_t;

endpackage

// File: rtl/vreg_rename_fl_if.sv
// Rename stage bus: instruction input handshake, renamed output handshake and the commit
// release port.
// master: producer of instructions / consumer of renamed results / commit source.
// slave : the rename block.
interface vreg_rename_fl_if import cellrv32_package::*; #(
  parameter int unsigned ARCH_REGS   = 32,
  parameter int unsigned PHYS_REGS   = 64,
  parameter int unsigned TICKET_BITS = TicketBits
);
  localparam int unsigned ArchW = $clog2(ARCH_REGS);
  localparam int unsigned PhysW = $clog2(PHYS_REGS);

  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [ArchW-1:0]       in_dst_i;
  logic [ArchW-1:0]       in_src1_i;
  logic [ArchW-1:0]       in_src2_i;
  logic                   in_wr_dst_i;

  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [PhysW-1:0]       out_pdst_o;
  logic [PhysW-1:0]       out_psrc1_o;
  logic [PhysW-1:0]       out_psrc2_o;
  logic [PhysW-1:0]       out_old_pdst_o;
  logic [TICKET_BITS-1:0] out_ticket_o;
  logic [TICKET_BITS-1:0] out_src1_ticket_o;
  logic [TICKET_BITS-1:0] out_src2_ticket_o;

  logic                   commit_valid_i;
  logic [PhysW-1:0]       commit_old_pdst_i;

  modport master (
    output in_valid_i, in_dst_i, in_src1_i, in_src2_i, in_wr_dst_i, out_ready_i,
    output commit_valid_i, commit_old_pdst_i,
    input  in_ready_o, out_valid_o, out_pdst_o, out_psrc1_o, out_psrc2_o, out_old_pdst_o,
    input  out_ticket_o, out_src1_ticket_o, out_src2_ticket_o
  );

  modport slave (
    input  in_valid_i, in_dst_i, in_src1_i, in_src2_i, in_wr_dst_i, out_ready_i,
    input  commit_valid_i, commit_old_pdst_i,
    output in_ready_o, out_valid_o, out_pdst_o, out_psrc1_o, out_psrc2_o, out_old_pdst_o,
    output out_ticket_o, out_src1_ticket_o, out_src2_ticket_o
  );

endinterface

// File: rtl/vreg_free_fifo.sv
// Circular free list of physical registers.
// Ports: clk_i/rstn_i (async active-low), flush_i (sync restore of reset contents),
//        pop_i/head_o (allocate head entry), push_i/push_data_i (release into tail),
//        count_o (occupancy), ovf_o (push attempted while full; the push is dropped).
// Reset contents: InitBase, InitBase+1, ... InitBase+Depth-1, head at slot 0, full.
module vreg_free_fifo #(
  parameter int unsigned Depth    = 32,
  parameter int unsigned DataW    = 6,
  parameter int unsigned InitBase = 32
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         flush_i,
  input  logic                         pop_i,
  input  logic                         push_i,
  input  logic [DataW-1:0]             push_data_i,
  output logic [DataW-1:0]             head_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         ovf_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] mem_d [Depth];
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_pop, do_push;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_pop  = pop_i & (count_q != '0);
    // Full means drop, even if a pop frees a slot in the same cycle.
    do_push = push_i & (count_q != CntW'(Depth));
    ovf_o   = push_i & (count_q == CntW'(Depth));

    if (flush_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_d[i] = DataW'(InitBase + i);
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = CntW'(Depth);
    end else begin
      if (do_push) begin
        mem_d[tail_q] = push_data_i;
        tail_d = (tail_q == PtrW'(Depth - 1)) ? '0 : tail_q + PtrW'(1);
      end
      if (do_pop) begin
        head_d = (head_q == PtrW'(Depth - 1)) ? '0 : head_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= DataW'(InitBase + i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CntW'(Depth);
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entries pushed this cycle only become visible next cycle.
  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/vreg_rename_fl.sv
// Vector register rename stage with free list, RAT and producer-ticket table.
// Ports: clk_i, rstn_i (async active-low), flush_i (one-cycle restore of reset state,
//        err_o kept), ren_if (slave: instruction in, renamed out, commit release),
//        free_count_o (free physical registers), err_o (sticky: release into a full list),
//        is_idle_o (no input offered and no output held).
module vreg_rename_fl import cellrv32_package::*; #(
  parameter int unsigned ARCH_REGS   = 32,
  parameter int unsigned PHYS_REGS   = 64,
  parameter int unsigned TICKET_BITS = TicketBits
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        flush_i,
  vreg_rename_fl_if.slave             ren_if,
  output logic [$clog2(PHYS_REGS):0]  free_count_o,
  output logic                        err_o,
  output logic                        is_idle_o
);
  localparam int unsigned PhysW   = $clog2(PHYS_REGS);
  localparam int unsigned FlDepth = PHYS_REGS - ARCH_REGS;
  localparam int unsigned FlCntW  = $clog2(FlDepth + 1);

  logic [PhysW-1:0]       rat_q      [ARCH_REGS];
  logic [PhysW-1:0]       rat_d      [ARCH_REGS];
  logic [TICKET_BITS-1:0] last_tkt_q [ARCH_REGS];
  logic [TICKET_BITS-1:0] last_tkt_d [ARCH_REGS];
  logic [TICKET_BITS-1:0] ticket_q, ticket_d;

  logic                   out_valid_q, out_valid_d;
  logic [PhysW-1:0]       pdst_q, pdst_d;
  logic [PhysW-1:0]       psrc1_q, psrc1_d;
  logic [PhysW-1:0]       psrc2_q, psrc2_d;
  logic [PhysW-1:0]       old_pdst_q, old_pdst_d;
  logic [TICKET_BITS-1:0] otkt_q, otkt_d;
  logic [TICKET_BITS-1:0] s1tkt_q, s1tkt_d;
  logic [TICKET_BITS-1:0] s2tkt_q, s2tkt_d;
  logic                   err_q, err_d;

  logic                   in_ready, accept, fl_pop, fl_push, fl_ovf;
  logic [PhysW-1:0]       fl_head;
  logic [FlCntW-1:0]      fl_count;
  logic [TICKET_BITS-1:0] s1_last, s2_last;

  vreg_free_fifo #(
    .Depth    (FlDepth),
    .DataW    (PhysW),
    .InitBase (ARCH_REGS)
  ) u_free_fifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .flush_i     (flush_i),
    .pop_i       (fl_pop),
    .push_i      (fl_push),
    .push_data_i (ren_if.commit_old_pdst_i),
    .head_o      (fl_head),
    .count_o     (fl_count),
    .ovf_o       (fl_ovf)
  );

  always_comb begin
    in_ready = (~out_valid_q | ren_if.out_ready_i)
             & (~ren_if.in_wr_dst_i | (fl_count != '0))
             & ~flush_i;
    accept   = ren_if.in_valid_i & in_ready;
    fl_pop   = accept & ren_if.in_wr_dst_i;
    fl_push  = ren_if.commit_valid_i & ~flush_i;
    s1_last  = last_tkt_q[ren_if.in_src1_i];
    s2_last  = last_tkt_q[ren_if.in_src2_i];

    rat_d       = rat_q;
    last_tkt_d  = last_tkt_q;
    ticket_d    = ticket_q;
    out_valid_d = out_valid_q;
    pdst_d      = pdst_q;
    psrc1_d     = psrc1_q;
    psrc2_d     = psrc2_q;
    old_pdst_d  = old_pdst_q;
    otkt_d      = otkt_q;
    s1tkt_d     = s1tkt_q;
    s2tkt_d     = s2tkt_q;
    err_d       = err_q | fl_ovf;

    if (flush_i) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        rat_d[i]      = PhysW'(i);
        last_tkt_d[i] = '0;
      end
      ticket_d    = TICKET_BITS'(1);
      out_valid_d = 1'b0;
      pdst_d      = '0;
      psrc1_d     = '0;
      psrc2_d     = '0;
      old_pdst_d  = '0;
      otkt_d      = '0;
      s1tkt_d     = '0;
      s2tkt_d     = '0;
    end else begin
      if (ren_if.out_ready_i) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        // Sources and old mapping come from the RAT before this instruction's own update.
        out_valid_d = 1'b1;
        old_pdst_d  = rat_q[ren_if.in_dst_i];
        pdst_d      = ren_if.in_wr_dst_i ? fl_head : rat_q[ren_if.in_dst_i];
        psrc1_d     = rat_q[ren_if.in_src1_i];
        psrc2_d     = rat_q[ren_if.in_src2_i];
        otkt_d      = ticket_q;
        // A zero entry means no producer in flight; fall back to the own ticket.
        s1tkt_d     = (s1_last != '0) ? s1_last : ticket_q;
        s2tkt_d     = (s2_last != '0) ? s2_last : ticket_q;
        ticket_d    = (ticket_q == '1) ? TICKET_BITS'(1) : ticket_q + TICKET_BITS'(1);
        if (ren_if.in_wr_dst_i) begin
          rat_d[ren_if.in_dst_i]      = fl_head;
          last_tkt_d[ren_if.in_dst_i] = ticket_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        rat_q[i]      <= PhysW'(i);
        last_tkt_q[i] <= '0;
      end
      ticket_q    <= TICKET_BITS'(1);
      out_valid_q <= 1'b0;
      pdst_q      <= '0;
      psrc1_q     <= '0;
      psrc2_q     <= '0;
      old_pdst_q  <= '0;
      otkt_q      <= '0;
      s1tkt_q     <= '0;
      s2tkt_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      rat_q       <= rat_d;
      last_tkt_q  <= last_tkt_d;
      ticket_q    <= ticket_d;
      out_valid_q <= out_valid_d;
      pdst_q      <= pdst_d;
      psrc1_q     <= psrc1_d;
      psrc2_q     <= psrc2_d;
      old_pdst_q  <= old_pdst_d;
      otkt_q      <= otkt_d;
      s1tkt_q     <= s1tkt_d;
      s2tkt_q     <= s2tkt_d;
      err_q       <= err_d;
    end
  end

  assign ren_if.in_ready_o        = in_ready;
  assign ren_if.out_valid_o       = out_valid_q;
  assign ren_if.out_pdst_o        = pdst_q;
  assign ren_if.out_psrc1_o       = psrc1_q;
  assign ren_if.out_psrc2_o       = psrc2_q;
  assign ren_if.out_old_pdst_o    = old_pdst_q;
  assign ren_if.out_ticket_o      = otkt_q;
  assign ren_if.out_src1_ticket_o = s1tkt_q;
  assign ren_if.out_src2_ticket_o = s2tkt_q;

  assign free_count_o = ($clog2(PHYS_REGS) + 1)'(fl_count);
  assign err_o        = err_q;
  assign is_idle_o    = ~ren_if.in_valid_i & ~out_valid_q;

endmodule

// File: doc/vreg_rename_fl.md
VREG_RENAME_FL -- requirements
Module: vreg_rename_fl

Interface
REQ-001 SHALL have parameter ARCH_REGS, default 32: number of architectural vector registers.
REQ-002 SHALL have parameter PHYS_REGS, default 64, required > ARCH_REGS: number of physical vector registers.
REQ-003 SHALL have parameter TICKET_BITS, default 4: width of the producer ticket.
REQ-004 SHALL have port clk_i, input, 1: clock.
REQ-005 SHALL have port rstn_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i, input, 1: reconfigure/flush.
REQ-007 SHALL have ports in_valid_i (input, 1) and in_ready_o (output, 1): instruction handshake.
REQ-008 SHALL have inputs in_dst_i, in_src1_i, in_src2_i, each log2(ARCH_REGS) wide: architectural registers.
REQ-009 SHALL have input in_wr_dst_i, 1: instruction writes dst (0 for stores).
REQ-010 SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1): output handshake.
REQ-011 SHALL have outputs out_pdst_o, out_psrc1_o, out_psrc2_o, out_old_pdst_o, each log2(PHYS_REGS) wide.
REQ-012 SHALL have outputs out_ticket_o, out_src1_ticket_o, out_src2_ticket_o, each TICKET_BITS wide.
REQ-013 SHALL have inputs commit_valid_i (1) and commit_old_pdst_i (log2(PHYS_REGS)): release of a physical register.
REQ-014 SHALL have outputs free_count_o (log2(PHYS_REGS)+1), err_o (1, sticky) and is_idle_o (1).

Function
REQ-015 SHALL keep the free list as a circular FIFO with depth PHYS_REGS-ARCH_REGS, head/tail pointers and an occupancy counter.
REQ-016 in_ready_o SHALL equal (~out_valid_o | out_ready_i) & (~in_wr_dst_i | free_count_o>0) & ~flush_i.
REQ-017 An accept (in_valid_i & in_ready_o) SHALL load the output register on the next edge; latency is 1 cycle.
REQ-018 On accept with in_wr_dst_i=1: pop the FIFO head into out_pdst_o; out_old_pdst_o = prior RAT[in_dst_i]; write RAT[in_dst_i] = popped register.
REQ-019 On accept with in_wr_dst_i=0: out_pdst_o = out_old_pdst_o = RAT[in_dst_i]; no pop, RAT and producer table unchanged.
REQ-020 psrc1/psrc2 SHALL use the RAT contents before this instruction's update, including when src equals dst.
REQ-021 The ticket counter SHALL start at 1 and advance on every accept, wrapping from 2^TICKET_BITS-1 to 1; 0 is never issued.
REQ-022 out_srcN_ticket_o SHALL equal last_ticket[in_srcN_i] when it is non-zero, else the instruction's own ticket.
REQ-023 When in_wr_dst_i=1, an accept SHALL write last_ticket[in_dst_i] = ticket.
REQ-024 commit_valid_i SHALL push commit_old_pdst_i at the tail; the pushed entry is not allocatable in the same cycle.
REQ-025 Simultaneous pop and push: count' = count + 1 - 1; pointers both advance.
REQ-026 commit_valid_i while count = PHYS_REGS-ARCH_REGS SHALL drop the push and set err_o.
REQ-027 When out_valid_o=1 and out_ready_i=0, the output SHALL hold stable.
REQ-028 flush_i SHALL, in one cycle, restore the reset state of RAT, free list, tickets and last_ticket, clear out_valid_o and ignore commit; err_o is kept.
REQ-029 is_idle_o SHALL equal ~in_valid_i & ~out_valid_o.

Reset
REQ-030 On reset: RAT[i] = i; free list holds ARCH_REGS..PHYS_REGS-1 in order with head at ARCH_REGS; free_count_o = PHYS_REGS-ARCH_REGS.
REQ-031 On reset: ticket = 1, last_ticket all 0, out_valid_o = 0, err_o = 0, all data outputs 0.
REQ-032 Reset assertion mid-operation SHALL abort any held output immediately (asynchronously).

Structure
REQ-033 A renamed-instruction struct type and a ticket-width constant SHALL live in cellrv32_package.
REQ-034 The free-list FIFO SHALL be a sub-module vreg_free_fifo; the RAT and last_ticket table are inline.

Verification
REQ-035 Bench SHALL cover: after reset, accept dst=3 wr=1 -> pdst=32, old_pdst=3, ticket=1, free_count=31.
REQ-036 Bench SHALL cover: 32 writes with no commit -> free_count=0, in_ready_o=0; a commit of 5 -> ready next cycle; next pdst=5.
REQ-037 Bench SHALL cover: instr src1=dst=7 after v7->40 -> psrc1=40, pdst is the new register, src1_ticket equals the producer of v7.
REQ-038 Bench SHALL cover: 16 accepts -> tickets 1..15 then 1; a store (wr=0) consumes a ticket but leaves free_count unchanged.
REQ-039 Bench SHALL cover: out_ready_i=0 for 3 cycles -> output stable, in_ready_o=0; flush_i -> RAT is identity and free_count=32.
REQ-040 Bench SHALL cover: commit while the free list is full -> err_o=1, free_count unchanged.
